// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: tracks shadow EX/MEM/WB stages to produce stall,
// flush and bubble controls plus per-port EX operand forwarding selects.
module pipeline_hazard_controller #(
    parameter int REG_INDEX_WIDTH     = 5,
    parameter int READ_PORTS          = 2,
    parameter int MULTI_CYCLE_LATENCY = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  idValid,
    input  logic [READ_PORTS*REG_INDEX_WIDTH-1:0] idReadIndex,
    input  logic [READ_PORTS-1:0]                 idReadUsed,
    input  logic [REG_INDEX_WIDTH-1:0]            idWriteIndex,
    input  logic                                  idRegWrite,
    input  logic                                  idMemRead,
    input  logic                                  idMultiCycle,
    input  logic                                  exBranchTaken,
    output logic                                  holdPC,
    output logic                                  holdIFID,
    output logic                                  flushIFID,
    output logic                                  bubbleIDEX,
    output logic                                  holdIDEX,
    output logic                                  bubbleEXMEM,
    output logic [READ_PORTS*2-1:0]               forwardSelect,
    output logic                                  exBusy
);

    localparam int W  = REG_INDEX_WIDTH;
    localparam int CW = $clog2(MULTI_CYCLE_LATENCY);
    localparam logic [CW-1:0] MC_RELOAD = CW'(MULTI_CYCLE_LATENCY - 1);

    // EX shadow stage
    logic                      exValidReg;
    logic                      exRegWriteReg;
    logic                      exMemReadReg;
    logic [W-1:0]              exWriteIndexReg;
    logic [READ_PORTS*W-1:0]   exReadIndexReg;
    logic [READ_PORTS-1:0]     exReadUsedReg;
    // MEM/WB only feed forwarding, so their memRead flag is not kept
    logic                      memValidReg;
    logic                      memRegWriteReg;
    logic [W-1:0]              memWriteIndexReg;
    logic                      wbValidReg;
    logic                      wbRegWriteReg;
    logic [W-1:0]              wbWriteIndexReg;
    logic [CW-1:0]             mcCountReg;

    logic                      busy;
    logic                      exSource;
    logic                      memSource;
    logic                      wbSource;
    logic                      loadUse;
    logic                      branchMode;
    logic                      loadUseMode;
    logic                      normalMode;
    logic [READ_PORTS-1:0]     portLoadHit;

    assign busy      = (mcCountReg != '0);
    assign exSource  = exValidReg  & exRegWriteReg  & (exWriteIndexReg  != '0);
    assign memSource = memValidReg & memRegWriteReg & (memWriteIndexReg != '0);
    assign wbSource  = wbValidReg  & wbRegWriteReg  & (wbWriteIndexReg  != '0);

    genvar gi;
    generate
        for (gi = 0; gi < READ_PORTS; gi++) begin : gPort
            logic [W-1:0] exIdx;
            logic         memHit;
            logic         wbHit;

            assign portLoadHit[gi] = idReadUsed[gi] &
                                     (idReadIndex[gi*W +: W] == exWriteIndexReg);

            // Forwarding looks only at registered state, never at ID inputs
            assign exIdx  = exReadIndexReg[gi*W +: W];
            assign memHit = exReadUsedReg[gi] & memSource & (memWriteIndexReg == exIdx);
            assign wbHit  = exReadUsedReg[gi] & wbSource  & (wbWriteIndexReg  == exIdx);
            assign forwardSelect[gi*2 +: 2] = memHit ? 2'b10 : (wbHit ? 2'b01 : 2'b00);
        end
    endgenerate

    assign loadUse     = idValid & exSource & exMemReadReg & (|portLoadHit);
    assign branchMode  = ~busy & exBranchTaken & exValidReg;
    assign loadUseMode = ~busy & ~branchMode & loadUse;
    assign normalMode  = ~busy & ~branchMode & ~loadUse;

    assign holdPC      = busy | loadUseMode;
    assign holdIFID    = busy | loadUseMode;
    assign flushIFID   = branchMode;
    assign bubbleIDEX  = branchMode | loadUseMode;
    assign holdIDEX    = busy;
    assign bubbleEXMEM = busy;
    assign exBusy      = busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exValidReg       <= 1'b0;
            exRegWriteReg    <= 1'b0;
            exMemReadReg     <= 1'b0;
            exWriteIndexReg  <= '0;
            exReadIndexReg   <= '0;
            exReadUsedReg    <= '0;
            memValidReg      <= 1'b0;
            memRegWriteReg   <= 1'b0;
            memWriteIndexReg <= '0;
            wbValidReg       <= 1'b0;
            wbRegWriteReg    <= 1'b0;
            wbWriteIndexReg  <= '0;
            mcCountReg       <= '0;
        end else begin
            wbValidReg      <= memValidReg;
            wbRegWriteReg   <= memRegWriteReg;
            wbWriteIndexReg <= memWriteIndexReg;

            if (busy) begin
                memValidReg    <= 1'b0;
                memRegWriteReg <= 1'b0;
                mcCountReg     <= mcCountReg - 1'b1;
            end else begin
                memValidReg      <= exValidReg;
                memRegWriteReg   <= exRegWriteReg;
                memWriteIndexReg <= exWriteIndexReg;
            end

            if (normalMode) begin
                exValidReg      <= idValid;
                exRegWriteReg   <= idRegWrite;
                exMemReadReg    <= idMemRead;
                exWriteIndexReg <= idWriteIndex;
                exReadIndexReg  <= idReadIndex;
                exReadUsedReg   <= idReadUsed;
                if (idValid && idMultiCycle) begin
                    mcCountReg <= MC_RELOAD;
                end
            end else if (!busy) begin
                exValidReg    <= 1'b0;
                exRegWriteReg <= 1'b0;
                exMemReadReg  <= 1'b0;
                exReadUsedReg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Testbench for pipeline_hazard_controller: directed hazard scenarios plus
// randomized traffic, all checked against an in-bench pipeline model.
module tb_pipeline_hazard_controller;

    localparam int W   = 5;
    localparam int RP  = 2;
    localparam int LAT = 4;

    localparam int M_NORMAL = 0;
    localparam int M_BUSY   = 1;
    localparam int M_BRANCH = 2;
    localparam int M_LOAD   = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              idValid;
    logic [RP*W-1:0]   idReadIndex;
    logic [RP-1:0]     idReadUsed;
    logic [W-1:0]      idWriteIndex;
    logic              idRegWrite;
    logic              idMemRead;
    logic              idMultiCycle;
    logic              exBranchTaken;
    logic              holdPC;
    logic              holdIFID;
    logic              flushIFID;
    logic              bubbleIDEX;
    logic              holdIDEX;
    logic              bubbleEXMEM;
    logic [RP*2-1:0]   forwardSelect;
    logic              exBusy;

    pipeline_hazard_controller #(
        .REG_INDEX_WIDTH(W),
        .READ_PORTS(RP),
        .MULTI_CYCLE_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .idValid(idValid),
        .idReadIndex(idReadIndex),
        .idReadUsed(idReadUsed),
        .idWriteIndex(idWriteIndex),
        .idRegWrite(idRegWrite),
        .idMemRead(idMemRead),
        .idMultiCycle(idMultiCycle),
        .exBranchTaken(exBranchTaken),
        .holdPC(holdPC),
        .holdIFID(holdIFID),
        .flushIFID(flushIFID),
        .bubbleIDEX(bubbleIDEX),
        .holdIDEX(holdIDEX),
        .bubbleEXMEM(bubbleEXMEM),
        .forwardSelect(forwardSelect),
        .exBusy(exBusy)
    );

    always #5 clk = ~clk;

    // One instruction record per occupied pipeline slot; index 0 = EX, 1 = MEM, 2 = WB.
    typedef struct packed {
        logic            v;
        logic            rw;
        logic            mr;
        logic [W-1:0]    wi;
        logic [RP*W-1:0] ri;
        logic [RP-1:0]   ru;
    } stg_t;

    stg_t pipe [3];
    int   mcLeft;
    int   mode;
    int   checks   = 0;
    int   failures = 0;

    logic            expHoldPC, expHoldIFID, expFlush, expBubbleIDEX;
    logic            expHoldIDEX, expBubbleEXMEM, expBusy;
    logic [RP*2-1:0] expFs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit producer(input stg_t s);
        return s.v && s.rw && (s.wi != 0);
    endfunction

    task automatic computeExpected();
        bit lu = 0;
        if (idValid && producer(pipe[0]) && pipe[0].mr)
            for (int i = 0; i < RP; i++)
                if (idReadUsed[i] && idReadIndex[i*W +: W] == pipe[0].wi) lu = 1;
        if (mcLeft > 0)                          mode = M_BUSY;
        else if (exBranchTaken && pipe[0].v)     mode = M_BRANCH;
        else if (lu)                             mode = M_LOAD;
        else                                     mode = M_NORMAL;
        expHoldPC      = (mode == M_BUSY) || (mode == M_LOAD);
        expHoldIFID    = expHoldPC;
        expFlush       = (mode == M_BRANCH);
        expBubbleIDEX  = (mode == M_BRANCH) || (mode == M_LOAD);
        expHoldIDEX    = (mode == M_BUSY);
        expBubbleEXMEM = (mode == M_BUSY);
        expBusy        = (mode == M_BUSY);
        for (int i = 0; i < RP; i++) begin
            logic [W-1:0] r;
            logic [1:0]   e;
            r = pipe[0].ri[i*W +: W];
            e = 2'b00;
            if (pipe[0].ru[i]) begin
                if (producer(pipe[1]) && pipe[1].wi == r)      e = 2'b10;
                else if (producer(pipe[2]) && pipe[2].wi == r) e = 2'b01;
            end
            expFs[i*2 +: 2] = e;
        end
    endtask

    task automatic checkAll();
        check("holdPC",        32'(holdPC),        32'(expHoldPC));
        check("holdIFID",      32'(holdIFID),      32'(expHoldIFID));
        check("flushIFID",     32'(flushIFID),     32'(expFlush));
        check("bubbleIDEX",    32'(bubbleIDEX),    32'(expBubbleIDEX));
        check("holdIDEX",      32'(holdIDEX),      32'(expHoldIDEX));
        check("bubbleEXMEM",   32'(bubbleEXMEM),   32'(expBubbleEXMEM));
        check("exBusy",        32'(exBusy),        32'(expBusy));
        check("forwardSelect", 32'(forwardSelect), 32'(expFs));
    endtask

    // Sample mid-cycle against the model.
    task automatic evalNow();
        @(negedge clk);
        computeExpected();
        checkAll();
    endtask

    // Clock edge: model retires/advances instructions exactly as the mode dictates.
    task automatic advance();
        @(posedge clk);
        case (mode)
            M_BUSY: begin
                pipe[2] = pipe[1];
                pipe[1] = '0;
                mcLeft--;
            end
            M_BRANCH, M_LOAD: begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = '0;
            end
            default: begin
                pipe[2] = pipe[1];
                pipe[1] = pipe[0];
                pipe[0] = {idValid, idRegWrite, idMemRead, idWriteIndex, idReadIndex, idReadUsed};
                if (idValid && idMultiCycle) mcLeft = LAT - 1;
            end
        endcase
        #1;
    endtask

    task automatic cycle();
        evalNow();
        advance();
    endtask

    task automatic setInstr(input bit v, input int rs0, input int rs1, input logic [1:0] used,
                            input int rd, input bit rw, input bit mr, input bit mc, input bit br);
        idValid       = v;
        idReadIndex   = {W'(rs1), W'(rs0)};
        idReadUsed    = used;
        idWriteIndex  = W'(rd);
        idRegWrite    = rw;
        idMemRead     = mr;
        idMultiCycle  = mc;
        exBranchTaken = br;
    endtask

    task automatic setIdle();
        setInstr(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endtask

    task automatic randId();
        setInstr($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                 2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 3; i++) pipe[i] = '0;
        mcLeft = 0;
    endtask

    // Assert reset away from any clock edge, confirm outputs drop at once, release later.
    task automatic doReset();
        reset = 1'b1;
        #1;
        clearModel();
        computeExpected();
        checkAll();
        check("rst_exBusy_async", 32'(exBusy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        setIdle();
        clearModel();
        mode = M_NORMAL;
        #2;
        computeExpected();
        checkAll();
        @(posedge clk);
        randId();
        #1;
        check("rst_hold_holdPC", 32'(holdPC), 32'd0);
        check("rst_hold_fs", 32'(forwardSelect), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        randId();
        evalNow();
        check("post_rst_holdPC", 32'(holdPC), 32'd0);
        check("post_rst_bubble", 32'(bubbleIDEX), 32'd0);
        advance();
        setIdle();
        repeat (3) cycle();

        // load x5 ; add x6,x5,x7
        setInstr(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cycle();
        setInstr(1, 5, 7, 2'b11, 6, 1, 0, 0, 0);
        evalNow();
        check("lu_holdPC", 32'(holdPC), 32'd1);
        check("lu_bubbleIDEX", 32'(bubbleIDEX), 32'd1);
        advance();
        evalNow();
        check("lu_once", 32'(holdPC), 32'd0);
        advance();
        setIdle();
        evalNow();
        check("lu_fwd_wb", 32'(forwardSelect[1:0]), 32'd1);
        advance();
        repeat (3) cycle();

        // add x5 ; sub x8,x5,x5 ; or x9,x5
        setInstr(1, 1, 2, 2'b11, 5, 1, 0, 0, 0); cycle();
        setInstr(1, 5, 5, 2'b11, 8, 1, 0, 0, 0); cycle();
        setInstr(1, 5, 0, 2'b01, 9, 1, 0, 0, 0);
        evalNow();
        check("fwd_mem_both", 32'(forwardSelect), 32'b1010);
        check("fwd_nostall", 32'(holdPC), 32'd0);
        advance();
        setIdle();
        evalNow();
        check("fwd_wb_later", 32'(forwardSelect[1:0]), 32'd1);
        advance();
        repeat (3) cycle();

        // load to x0 ; reader of x0
        setInstr(1, 0, 0, 2'b00, 0, 1, 1, 0, 0); cycle();
        setInstr(1, 0, 0, 2'b11, 3, 1, 0, 0, 0);
        evalNow();
        check("x0_nostall", 32'(holdPC), 32'd0);
        advance();
        setIdle();
        evalNow();
        check("x0_fwd", 32'(forwardSelect), 32'd0);
        advance();
        repeat (3) cycle();

        // multi-cycle op
        setInstr(1, 1, 2, 2'b11, 4, 1, 0, 1, 0); cycle();
        setInstr(1, 4, 0, 2'b01, 6, 1, 0, 0, 0);
        for (int k = 0; k < LAT - 1; k++) begin
            evalNow();
            check("mc_busy", 32'(exBusy), 32'd1);
            check("mc_holdIDEX", 32'(holdIDEX), 32'd1);
            check("mc_bubbleEXMEM", 32'(bubbleEXMEM), 32'd1);
            advance();
        end
        evalNow();
        check("mc_done", 32'(exBusy), 32'd0);
        advance();
        setIdle();
        repeat (4) cycle();

        // branch taken while load-use condition also present
        setInstr(1, 0, 0, 2'b00, 5, 1, 1, 0, 0); cycle();
        setInstr(1, 5, 0, 2'b01, 6, 1, 0, 0, 1);
        evalNow();
        check("br_flush", 32'(flushIFID), 32'd1);
        check("br_bubble", 32'(bubbleIDEX), 32'd1);
        check("br_holdPC", 32'(holdPC), 32'd0);
        advance();
        exBranchTaken = 1'b0;
        evalNow();
        check("br_next_flush", 32'(flushIFID), 32'd0);
        check("br_next_hold", 32'(holdPC), 32'd0);
        advance();
        setIdle();
        repeat (3) cycle();

        // reset in the middle of a multi-cycle op (count 2)
        setInstr(1, 1, 2, 2'b11, 4, 1, 0, 1, 0); cycle();
        setIdle();
        cycle();
        #2;
        doReset();
        evalNow();
        check("mcrst_busy", 32'(exBusy), 32'd0);
        check("mcrst_holdIDEX", 32'(holdIDEX), 32'd0);
        advance();

        for (int n = 0; n < 3000; n++) begin
            randId();
            cycle();
            if ($urandom_range(0, 299) == 0) doReset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
